// File: rtl/dmac_ch_arbiter.sv
// Round-robin arbiter that shares one DMA transfer engine between N_CH channels.
// Optional macro DMAC_ARB_PRIO_EN adds prio_i for a two-class priority scheme.
module dmac_ch_arbiter #(
  parameter int N_CH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      req_i,
`ifdef DMAC_ARB_PRIO_EN
  input  logic [N_CH-1:0]      prio_i,
`endif
  input  logic [32*N_CH-1:0]   src_addr_i,
  input  logic [32*N_CH-1:0]   dst_addr_i,
  input  logic [16*N_CH-1:0]   byte_len_i,
  input  logic                 done_i,
  output logic [N_CH-1:0]      gnt_o,
  output logic [N_CH-1:0]      ch_done_o,
  output logic                 start_o,
  output logic [31:0]          src_addr_o,
  output logic [31:0]          dst_addr_o,
  output logic [15:0]          byte_len_o
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] BUSY  = 2'd2;

  logic [1:0]      state_reg;
  logic [CW-1:0]   last_ch_reg;
  logic [CW-1:0]   winner_reg;
  logic [N_CH-1:0] gnt_reg;
  logic [N_CH-1:0] ch_done_reg;
  logic [31:0]     src_reg;
  logic [31:0]     dst_reg;
  logic [15:0]     len_reg;

  logic [31:0]     src_arr [N_CH];
  logic [31:0]     dst_arr [N_CH];
  logic [15:0]     len_arr [N_CH];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
    assign src_arr[gi] = src_addr_i[32*gi +: 32];
    assign dst_arr[gi] = dst_addr_i[32*gi +: 32];
    assign len_arr[gi] = byte_len_i[16*gi +: 16];
  end

  logic [N_CH-1:0] cand;
  logic            found;
  logic [CW-1:0]   winner_next;
  logic [CW-1:0]   idx_w;
  int              idx;

  // Search starts just past the last served channel, so it ends up lowest priority.
  always_comb begin
    cand = req_i;
`ifdef DMAC_ARB_PRIO_EN
    if ((req_i & prio_i) != '0) cand = req_i & prio_i;
`endif
    found       = 1'b0;
    winner_next = last_ch_reg;
    idx         = 0;
    idx_w       = '0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = int'(last_ch_reg) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      idx_w = CW'(idx);
      if (!found && cand[idx_w]) begin
        found       = 1'b1;
        winner_next = idx_w;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      last_ch_reg <= CW'(N_CH - 1);
      winner_reg  <= '0;
      gnt_reg     <= '0;
      ch_done_reg <= '0;
      src_reg     <= '0;
      dst_reg     <= '0;
      len_reg     <= '0;
    end else begin
      ch_done_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (found) begin
            state_reg  <= GRANT;
            winner_reg <= winner_next;
            gnt_reg    <= N_CH'(1) << winner_next;
            src_reg    <= src_arr[winner_next];
            dst_reg    <= dst_arr[winner_next];
            len_reg    <= len_arr[winner_next];
          end
        end
        GRANT: begin
          if (len_reg != 16'd0) begin
            state_reg <= BUSY;
          end else begin
            // Zero-length request completes without ever touching the engine.
            state_reg   <= IDLE;
            gnt_reg     <= '0;
            ch_done_reg <= gnt_reg;
            last_ch_reg <= winner_reg;
          end
        end
        BUSY: begin
          if (done_i) begin
            state_reg   <= IDLE;
            gnt_reg     <= '0;
            ch_done_reg <= gnt_reg;
            last_ch_reg <= winner_reg;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign gnt_o      = gnt_reg;
  assign ch_done_o  = ch_done_reg;
  assign start_o    = (state_reg == GRANT) && (len_reg != 16'd0);
  assign src_addr_o = src_reg;
  assign dst_addr_o = dst_reg;
  assign byte_len_o = len_reg;

endmodule

// File: tb/tb_dmac_ch_arbiter.sv
// Directed bench for dmac_ch_arbiter: grant order, zero-length, reset and done handling.
// Define DMAC_ARB_PRIO_EN to also exercise the priority class.
module tb_dmac_ch_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [3:0]   prio;
  logic [127:0] src_bus;
  logic [127:0] dst_bus;
  logic [63:0]  len_bus;
  logic         done;
  logic [3:0]   gnt;
  logic [3:0]   ch_done;
  logic         start;
  logic [31:0]  src_o;
  logic [31:0]  dst_o;
  logic [15:0]  len_o;

  logic [15:0]  lens [4];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmac_ch_arbiter #(.N_CH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
`ifdef DMAC_ARB_PRIO_EN
    .prio_i     (prio),
`endif
    .src_addr_i (src_bus),
    .dst_addr_i (dst_bus),
    .byte_len_i (len_bus),
    .done_i     (done),
    .gnt_o      (gnt),
    .ch_done_o  (ch_done),
    .start_o    (start),
    .src_addr_o (src_o),
    .dst_addr_o (dst_o),
    .byte_len_o (len_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] src_of(input int k);
    return 32'h1000_0000 + 32'(k) * 32'h100;
  endfunction

  function automatic logic [31:0] dst_of(input int k);
    return 32'h2000_0000 + 32'(k) * 32'h100;
  endfunction

  task automatic load_bus();
    for (int k = 0; k < 4; k++) begin
      src_bus[32*k +: 32] = src_of(k);
      dst_bus[32*k +: 32] = dst_of(k);
      len_bus[16*k +: 16] = lens[k];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    step();
    done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; prio = '0; done = 1'b0;
    lens[0] = 16'h40; lens[1] = 16'h80; lens[2] = 16'h20; lens[3] = 16'h10;
    load_bus();
    repeat (2) @(negedge clk);

    check("rst_gnt", 64'(gnt), 64'h0);
    check("rst_done", 64'(ch_done), 64'h0);
    check("rst_start", 64'(start), 64'h0);
    check("rst_src", 64'(src_o), 64'h0);
    check("rst_len", 64'(len_o), 64'h0);
    rst = 1'b0;

    // Single transfer on ch0, done 10 cycles after start
    req = 4'b0001;
    step();
    check("t1_gnt", 64'(gnt), 64'h1);
    check("t1_start", 64'(start), 64'h1);
    check("t1_src", 64'(src_o), 64'h1000_0000);
    check("t1_dst", 64'(dst_o), 64'h2000_0000);
    check("t1_len", 64'(len_o), 64'h40);
    req = '0;
    step();
    check("t1_busy_start", 64'(start), 64'h0);
    repeat (8) step();
    check("t1_hold_gnt", 64'(gnt), 64'h1);
    check("t1_hold_src", 64'(src_o), 64'h1000_0000);
    check("t1_early_done", 64'(ch_done), 64'h0);
    step();
    pulse_done();
    check("t1_ch_done", 64'(ch_done), 64'h1);
    check("t1_idle_gnt", 64'(gnt), 64'h0);
    step();
    check("t1_done_once", 64'(ch_done), 64'h0);
    $display("xfer ch0 len 40 complete");

    // All channels requesting: round-robin order 0,1,2,3,0
    do_reset();
    req = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rr%0d_gnt", k), 64'(gnt), 64'(4'b0001 << (k % 4)));
      check($sformatf("rr%0d_start", k), 64'(start), 64'h1);
      check($sformatf("rr%0d_len", k), 64'(len_o), 64'(lens[k % 4]));
      if (k == 4) req = '0;
      repeat (5) step();
      pulse_done();
      check($sformatf("rr%0d_ch_done", k), 64'(ch_done), 64'(4'b0001 << (k % 4)));
      check($sformatf("rr%0d_no_start", k), 64'(start), 64'h0);
      check($sformatf("rr%0d_idle_gnt", k), 64'(gnt), 64'h0);
      step();
      $display("xfer rr slot %0d ch%0d complete", k, k % 4);
    end
    check("rr_final_idle", 64'(gnt), 64'h0);

    // Zero-length request on ch2
    lens[2] = 16'h0;
    load_bus();
    req = 4'b0100;
    step();
    check("z_gnt", 64'(gnt), 64'h4);
    check("z_start", 64'(start), 64'h0);
    req = '0;
    step();
    check("z_ch_done", 64'(ch_done), 64'h4);
    check("z_gnt_off", 64'(gnt), 64'h0);
    check("z_start_off", 64'(start), 64'h0);
    step();
    check("z_done_once", 64'(ch_done), 64'h0);
    lens[2] = 16'h20;
    load_bus();
    $display("xfer ch2 zero-length complete");

    // Reset during BUSY on ch1
    req = 4'b0010;
    step();
    check("r_gnt", 64'(gnt), 64'h2);
    req = '0;
    step();
    step();
    check("r_busy_gnt", 64'(gnt), 64'h2);
    #2 rst = 1'b1;
    #1;
    check("r_async_gnt", 64'(gnt), 64'h0);
    check("r_async_start", 64'(start), 64'h0);
    check("r_async_done", 64'(ch_done), 64'h0);
    check("r_async_src", 64'(src_o), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("r_no_done", 64'(ch_done), 64'h0);
    req = 4'b1010;
    step();
    check("r_after_gnt", 64'(gnt), 64'h2);
    req = '0;
    step();
    pulse_done();
    check("r_after_ch_done", 64'(ch_done), 64'h2);
    $display("xfer ch1 after reset complete");

    // Stray done in IDLE, request dropped during BUSY
    pulse_done();
    check("s_idle_gnt", 64'(gnt), 64'h0);
    check("s_idle_done", 64'(ch_done), 64'h0);
    check("s_idle_start", 64'(start), 64'h0);
    req = 4'b1000;
    step();
    check("s_gnt", 64'(gnt), 64'h8);
    check("s_src", 64'(src_o), 64'h1000_0300);
    step();
    req = '0;
    step();
    check("s_hold_gnt", 64'(gnt), 64'h8);
    pulse_done();
    check("s_ch_done", 64'(ch_done), 64'h8);
    $display("xfer ch3 with dropped req complete");

    // Just-served channel as sole requester is granted again; else it loses
    req = 4'b1000;
    step();
    check("sole_gnt", 64'(gnt), 64'h8);
    req = '0;
    step();
    pulse_done();
    check("sole_ch_done", 64'(ch_done), 64'h8);
    req = 4'b1001;
    step();
    check("low_prio_gnt", 64'(gnt), 64'h1);
    req = '0;
    step();
    pulse_done();
    check("low_prio_ch_done", 64'(ch_done), 64'h1);
    $display("xfer sole/low-priority pair complete");

`ifdef DMAC_ARB_PRIO_EN
    do_reset();
    req = 4'b1111;
    prio = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("p%0d_gnt", k), 64'(gnt), 64'h8);
      step();
      pulse_done();
      check($sformatf("p%0d_ch_done", k), 64'(ch_done), 64'h8);
      $display("xfer prio ch3 round %0d complete", k);
    end
    req = '0;
    prio = '0;
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
